// File: rtl/segscan_capture.sv
// Receive side of a multiplexed 7-segment bus: rebuilds one 10-digit
// frame from the pads and decodes every digit back to a hex nibble.
module segscan_capture #(
  parameter int NDIG        = 10,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter bit SEL_ACT_LOW = 1'b0,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NDIG-1:0] sel_in,
  input  logic [7:0]      segm_in,
  input  logic [3:0]      rd_idx,
  output logic [3:0]      rd_digit,
  output logic            rd_dp,
  output logic            rd_known,
  output logic            frame_stb,
  output logic [7:0]      frame_cnt,
  output logic            err_multi,
  output logic            err_tmo
);

  localparam int DW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [NDIG-1:0] SEL_INV = {NDIG{SEL_ACT_LOW}};
  localparam logic [7:0]      SEG_INV = {8{SEG_ACT_LOW}};
  localparam logic [NDIG-1:0] ALL_ONES = '1;
  localparam logic [NDIG-1:0] BIT0 = NDIG'(1);

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    COPY
  } state_t;

  // slot word: [5]=known [4]=dp [3:0]=digit
  typedef logic [5:0] slot_t;

  logic [NDIG-1:0] sel_m;
  logic [NDIG-1:0] sel_s;
  logic [7:0]      seg_m;
  logic [7:0]      seg_s;
  logic [NDIG-1:0] sel_n;
  logic [7:0]      seg_n;

  logic [NDIG-1:0] prev_sel;
  logic [7:0]      prev_seg;
  logic [DW-1:0]   dwell_cnt;

  logic            sample;
  logic            samp_zero;
  logic            samp_one;
  logic [3:0]      samp_idx;
  logic            digit_smp;
  logic            multi_smp;
  slot_t           samp_word;

  state_t          state_q;
  state_t          state_d;
  logic [NDIG-1:0] mask_q;
  logic [NDIG-1:0] mask_d;
  logic [TW-1:0]   tmo_q;
  logic [TW-1:0]   tmo_d;
  logic            sh_we;
  logic            copy;
  logic            set_multi;
  logic            set_tmo;

  slot_t           shadow [NDIG];
  slot_t           disp   [NDIG];

  function automatic logic [4:0] dec7(
    input logic [6:0] s
  );
    logic [4:0] r;
    case (s)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // sync flops reset to the idle pad level so nothing looks selected
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_m <= SEL_INV;
      sel_s <= SEL_INV;
      seg_m <= SEG_INV;
      seg_s <= SEG_INV;
    end else begin
      sel_m <= sel_in;
      sel_s <= sel_m;
      seg_m <= segm_in;
      seg_s <= seg_m;
    end
  end

  assign sel_n = sel_s ^ SEL_INV;
  assign seg_n = seg_s ^ SEG_INV;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sel  <= '0;
      prev_seg  <= '0;
      dwell_cnt <= '0;
    end else begin
      prev_sel <= sel_n;
      prev_seg <= seg_n;
      if (sel_n != prev_sel) begin
        dwell_cnt <= '0;
      end else if (dwell_cnt != DW'(STABLE_CYC)) begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  // prev_* hold the value that has been stable for the whole dwell
  assign sample    = (dwell_cnt == DW'(STABLE_CYC - 1));
  assign samp_zero = (prev_sel == '0);
  assign samp_one  = !samp_zero &&
                     ((prev_sel & (prev_sel - 1'b1)) == '0);
  assign digit_smp = sample && samp_one;
  assign multi_smp = sample && !samp_zero && !samp_one;

  always_comb begin
    samp_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (prev_sel[i]) begin
        samp_idx = i[3:0];
      end
    end
  end

  always_comb begin
    logic [4:0] d;
    d = dec7(prev_seg[6:0]);
    samp_word = {d[4], prev_seg[7], d[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      mask_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    tmo_d     = tmo_q;
    sh_we     = 1'b0;
    copy      = 1'b0;
    set_multi = 1'b0;
    set_tmo   = 1'b0;
    unique case (state_q)
      HUNT: begin
        tmo_d = '0;
        if (multi_smp) begin
          set_multi = 1'b1;
          mask_d    = '0;
        end else if (digit_smp && samp_idx == 4'd0) begin
          sh_we   = 1'b1;
          mask_d  = BIT0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (multi_smp) begin
          set_multi = 1'b1;
          mask_d    = '0;
          tmo_d     = '0;
          state_d   = HUNT;
        end else if (digit_smp) begin
          sh_we = 1'b1;
          tmo_d = '0;
          if (samp_idx == 4'd0) begin
            mask_d = BIT0;
          end else begin
            mask_d = mask_q | (BIT0 << samp_idx);
          end
          if (mask_d == ALL_ONES) begin
            state_d = COPY;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
          set_tmo = 1'b1;
          mask_d  = '0;
          tmo_d   = '0;
          state_d = HUNT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COPY: begin
        copy    = 1'b1;
        mask_d  = '0;
        tmo_d   = '0;
        state_d = HUNT;
        if (multi_smp) begin
          set_multi = 1'b1;
        end
      end
      default: begin
        mask_d  = '0;
        tmo_d   = '0;
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) begin
        shadow[i] <= '0;
        disp[i]   <= '0;
      end
    end else begin
      if (sh_we) begin
        shadow[samp_idx] <= samp_word;
      end
      if (copy) begin
        disp <= shadow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_stb <= 1'b0;
      frame_cnt <= '0;
      err_multi <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      frame_stb <= copy;
      frame_cnt <= frame_cnt + 8'(copy);
      if (set_multi) begin
        err_multi <= 1'b1;
      end
      if (set_tmo) begin
        err_tmo <= 1'b1;
      end
    end
  end

  // registered readback sees disp before any copy on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_digit <= '0;
      rd_dp    <= 1'b0;
      rd_known <= 1'b0;
    end else if (32'(rd_idx) < NDIG) begin
      rd_digit <= disp[rd_idx][3:0];
      rd_dp    <= disp[rd_idx][4];
      rd_known <= disp[rd_idx][5];
    end else begin
      rd_digit <= '0;
      rd_dp    <= 1'b0;
      rd_known <= 1'b0;
    end
  end

endmodule

// File: tb/tb_segscan_capture.sv
// Scoreboard bench: two capture instances (active-high and active-low pads)
// fed the same logical display stream; frames are read back on frame_stb.
module tb_segscan_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sel_pad;
  logic [7:0] seg_pad;
  logic [3:0] rd_idx;

  logic [3:0] rd_digit0, rd_digit1;
  logic       rd_dp0, rd_dp1;
  logic       rd_known0, rd_known1;
  logic       stb0, stb1;
  logic [7:0] fc0, fc1;
  logic       em0, em1;
  logic       et0, et1;

  always #5 clk = ~clk;

  segscan_capture #(
    .NDIG(10), .STABLE_CYC(4), .TIMEOUT_CYC(65535),
    .SEL_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)
  ) u0 (
    .clk(clk), .rst(rst),
    .sel_in(sel_pad), .segm_in(seg_pad), .rd_idx(rd_idx),
    .rd_digit(rd_digit0), .rd_dp(rd_dp0), .rd_known(rd_known0),
    .frame_stb(stb0), .frame_cnt(fc0),
    .err_multi(em0), .err_tmo(et0)
  );

  segscan_capture #(
    .NDIG(10), .STABLE_CYC(4), .TIMEOUT_CYC(200),
    .SEL_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
  ) u1 (
    .clk(clk), .rst(rst),
    .sel_in(~sel_pad), .segm_in(~seg_pad), .rd_idx(rd_idx),
    .rd_digit(rd_digit1), .rd_dp(rd_dp1), .rd_known(rd_known1),
    .frame_stb(stb1), .frame_cnt(fc1),
    .err_multi(em1), .err_tmo(et1)
  );

  typedef struct packed {
    logic [39:0] dig;
    logic [9:0]  dp;
    logic [9:0]  kn;
    logic [7:0]  cnt;
  } frame_t;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  frame_t     exp_q [$];
  frame_t     last_f;
  logic [7:0] segs [10];
  int         exp_cnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         busy = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [7:0] s);
    logic [4:0] r;
    r = 5'h00;
    for (int i = 0; i < 16; i++) begin
      if (s[6:0] == glyph[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  task automatic expect_frame();
    frame_t     f;
    logic [4:0] d;
    f = '0;
    for (int k = 0; k < 10; k++) begin
      d = ref_dec(segs[k]);
      f.dig[k*4 +: 4] = d[3:0];
      f.kn[k] = d[4];
      f.dp[k] = segs[k][7];
    end
    exp_cnt = (exp_cnt + 1) % 256;
    f.cnt = 8'(exp_cnt);
    last_f = f;
    exp_q.push_back(f);
  endtask

  task automatic readback(input string tag, input frame_t f);
    logic [3:0] idx;
    logic [5:0] want;
    for (int k = 0; k < 12; k++) begin
      idx = (k < 10) ? 4'(k) : ((k == 10) ? 4'd10 : 4'd15);
      rd_idx = idx;
      @(negedge clk);
      want = (idx < 10) ?
             {f.kn[idx], f.dp[idx], f.dig[idx*4 +: 4]} : 6'h00;
      chk($sformatf("%s rd0 idx%0d", tag, idx),
          32'({rd_known0, rd_dp0, rd_digit0}), 32'(want));
      chk($sformatf("%s rd1 idx%0d", tag, idx),
          32'({rd_known1, rd_dp1, rd_digit1}), 32'(want));
    end
  endtask

  task automatic show(input int k, input logic [7:0] s, input int n);
    sel_pad = 10'b1 << k;
    seg_pad = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    sel_pad = '0;
    seg_pad = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sweep(input int first, input int last, input int n);
    for (int k = first; k <= last; k++) show(k, segs[k], n);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " frame arrival"}, 32'(exp_q.size()), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " out0"},
        32'({rd_digit0, rd_dp0, rd_known0, stb0, fc0, em0, et0}), 0);
    chk({tag, " out1"},
        32'({rd_digit1, rd_dp1, rd_known1, stb1, fc1, em1, et1}), 0);
  endtask

  // monitor: every frame_stb pops one expected frame and reads it back
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (stb0 || stb1) begin
        busy = 1'b1;
        chk("stb pair", 32'({stb0, stb1}), 32'b11);
        if (exp_q.size() == 0) begin
          chk("unexpected frame_stb", 32'(exp_q.size()), 1);
        end else begin
          f = exp_q.pop_front();
          chk("frame_cnt0", 32'(fc0), 32'(f.cnt));
          chk("frame_cnt1", 32'(fc1), 32'(f.cnt));
          readback("frm", f);
        end
        busy = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    sel_pad = '0;
    seg_pad = '0;
    rd_idx = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    blank(10);

    // T1: glyphs 0..9, dp on digit 3
    for (int k = 0; k < 10; k++) segs[k] = {1'b0, glyph[k]};
    segs[3][7] = 1'b1;
    expect_frame();
    sweep(0, 9, 8);
    blank(30);
    drain("T1");
    chk("T1 frame_cnt", 32'(fc0), 1);

    // T2: 3-cycle dwell never samples, 4-cycle dwell does
    for (int k = 0; k < 10; k++) segs[k] = {1'b0, glyph[9-k]};
    sweep(0, 9, 3);
    blank(40);
    chk("T2 short dwell cnt", 32'(fc0), 32'(exp_cnt));
    chk("T2 short dwell stb", 32'(exp_q.size()), 0);
    expect_frame();
    sweep(0, 9, 4);
    blank(30);
    drain("T2");

    // T3: partial sweep then restart
    for (int k = 0; k < 10; k++) segs[k] = {1'b0, glyph[(k+3)%16]};
    sweep(0, 5, 8);
    for (int k = 0; k < 10; k++) segs[k] = {1'b0, glyph[15-k]};
    segs[0][7] = 1'b1;
    segs[9][7] = 1'b1;
    expect_frame();
    sweep(0, 9, 6);
    blank(30);
    drain("T3");
    chk("T3 frame_cnt", 32'(fc1), 3);

    // T4: multi-hot select mid-sweep
    chk("T4 err_multi pre", 32'({em0, em1}), 0);
    for (int k = 0; k < 10; k++) segs[k] = {1'b0, glyph[(k*7)%16]};
    sweep(0, 1, 8);
    sel_pad = 10'h005;
    seg_pad = segs[2];
    repeat (8) @(negedge clk);
    sweep(3, 9, 8);
    blank(30);
    chk("T4 err_multi", 32'({em0, em1}), 32'b11);
    chk("T4 no frame", 32'(fc0), 32'(exp_cnt));
    expect_frame();
    sweep(0, 9, 8);
    blank(30);
    drain("T4");

    // T5: unknown pattern on digit 7
    for (int k = 0; k < 10; k++) segs[k] = {1'b0, glyph[k+6]};
    segs[7] = 8'h49;
    segs[5][7] = 1'b1;
    expect_frame();
    sweep(0, 9, 8);
    blank(30);
    drain("T5");

    // T6: stall after digit 4; only the short-timeout instance trips
    for (int k = 0; k < 10; k++) segs[k] = {1'b1, glyph[k]};
    sweep(0, 4, 8);
    blank(300);
    chk("T6 err_tmo0", 32'(et0), 0);
    chk("T6 err_tmo1", 32'(et1), 1);
    chk("T6 cnt kept", 32'(fc1), 32'(exp_cnt));
    readback("T6 keep", last_f);

    sweep(0, 3, 8);
    rst = 1'b1;
    rd_idx = 4'd3;
    repeat (2) @(negedge clk);
    chk_idle("midrst");
    rst = 1'b0;
    sweep(4, 9, 8);
    blank(20);
    chk("T6 hunt after rst", 32'(fc0), 0);
    exp_cnt = 0;
    for (int k = 0; k < 10; k++) segs[k] = {1'b0, glyph[k]};
    expect_frame();
    sweep(0, 9, 8);
    blank(30);
    drain("T6");
    chk("T6 cnt after rst", 32'(fc1), 1);
    chk("T6 errs cleared", 32'({em0, em1, et0, et1}), 0);

    chk("scoreboard empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
